// File: rtl/bias_accum_relu.sv
// bias_accum_relu: per-lane partial-sum accumulator with bias add, optional ReLU and output saturation
module bias_accum_relu #(
  parameter int N_adder_tree = 16,
  parameter int IN_W = 18,
  parameter int ACC_W = 24,
  parameter int OUT_W = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_adder_tree*18-1:0]   bias,
  input  logic                         relu_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [N_adder_tree*IN_W-1:0] psum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_adder_tree*OUT_W-1:0] out_data,
  output logic                         acc_ovf,
  output logic                         out_sat
);
  localparam int BW = 18;
  localparam int N = N_adder_tree;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  typedef enum logic [1:0] {ACC, BIAS, HOLD} state_t;
  state_t state, state_nx;
  logic alive, first, beat, hs, relu_q;
  logic [ACC_W-1:0] acc [N];
  logic [ACC_W-1:0] acc_nx [N];
  logic [ACC_W:0] sum [N];
  logic [ACC_W-1:0] relu_v [N];
  logic [N-1:0] lane_ovf, lane_clip;
  logic [N*OUT_W-1:0] out_nx;
  assign beat = in_valid && in_ready;
  assign hs = out_valid && out_ready;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else state <= state_nx;
  // next-state: collect beats, one bias cycle, then hold until the result is taken
  always_comb begin
    state_nx = state;
    case (state)
      ACC:     if (beat && in_last) state_nx = BIAS;
      BIAS:    state_nx = HOLD;
      HOLD:    if (hs) state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end
  // output decode: input side open only while accumulating and out of reset
  always_comb in_ready = alive && state == ACC;
  // keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) alive <= 1'b0;
    else alive <= 1'b1;
  // per-lane saturating add of psum (ACC) or bias (BIAS), plus ReLU/clip of the finished sum
  always_comb begin
    lane_ovf = '0;
    lane_clip = '0;
    out_nx = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = ((state == ACC && first) ? '0 : {acc[i][ACC_W-1], acc[i]})
             + ((state == BIAS) ? {{(ACC_W+1-BW){bias[BW*i+BW-1]}}, bias[BW*i +: BW]}
                                : {{(ACC_W+1-IN_W){psum[IN_W*i+IN_W-1]}}, psum[IN_W*i +: IN_W]});
      lane_ovf[i] = sum[i][ACC_W] ^ sum[i][ACC_W-1];
      acc_nx[i] = lane_ovf[i] ? (sum[i][ACC_W] ? ACC_MIN : ACC_MAX) : sum[i][ACC_W-1:0];
      relu_v[i] = (relu_q && acc[i][ACC_W-1]) ? '0 : acc[i];
      lane_clip[i] = !(&relu_v[i][ACC_W-1:OUT_W-1] || ~|relu_v[i][ACC_W-1:OUT_W-1]);
      out_nx[OUT_W*i +: OUT_W] = lane_clip[i] ? (relu_v[i][ACC_W-1] ? OUT_MIN : OUT_MAX)
                                              : relu_v[i][OUT_W-1:0];
    end
  end
  // accumulators, group-start flag, sticky overflow and the ReLU mode captured with the bias
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '{default: '0};
      first <= 1'b1;
      acc_ovf <= 1'b0;
      relu_q <= 1'b0;
    end else if (beat) begin
      acc <= acc_nx;
      first <= 1'b0;
      acc_ovf <= (acc_ovf && !first) || |lane_ovf;
    end else if (state == BIAS) begin
      acc <= acc_nx;
      acc_ovf <= acc_ovf || |lane_ovf;
      relu_q <= relu_en;
    end else if (hs) first <= 1'b1;
  // result register: loaded once on the first HOLD cycle, held until handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else if (state == HOLD && !out_valid) begin
      out_valid <= 1'b1;
      out_data <= out_nx;
      out_sat <= |lane_clip;
    end else if (hs) out_valid <= 1'b0;
endmodule
